// File: rtl/chunked_add_sub.sv
// ============================================================================
// chunked_add_sub : multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock
// Revision: 1.0
// ============================================================================
`default_nettype none

module chunked_add_sub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_k;
  logic [WIDTH-1:0] r_z;
  logic             r_cout;
  logic             r_ovf;

  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK:0]   w_sum;
  logic             w_last;

  // The one shared CHUNK-bit slice; carry bit of w_sum feeds r_carry.
  assign w_a_chunk = r_a[r_k*CHUNK +: CHUNK];
  assign w_b_chunk = r_b[r_k*CHUNK +: CHUNK];
  assign w_sum     = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
  assign w_last    = (r_k == CW'(NCHUNK - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_k     <= '0;
      r_z     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= x;
            r_b     <= y ^ {WIDTH{sub}};
            r_carry <= sub ? 1'b1 : cin;
            r_k     <= '0;
          end
        end
        S_RUN: begin
          r_z[r_k*CHUNK +: CHUNK] <= w_sum[CHUNK-1:0];
          r_carry                 <= w_sum[CHUNK];
          r_k                     <= r_k + 1'b1;
          if (w_last) begin
            // MSBs of the top chunk are the operand/result sign bits.
            r_cout <= w_sum[CHUNK];
            r_ovf  <= (w_a_chunk[CHUNK-1] == w_b_chunk[CHUNK-1]) &&
                      (w_sum[CHUNK-1] != w_a_chunk[CHUNK-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign z         = r_z;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_chunked_add_sub.sv
// ============================================================================
// tb_chunked_add_sub : randomized and directed checks over four parameter sets
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_chunked_add_sub;

  localparam int WD [4] = '{16, 16, 16, 32};
  localparam int CH [4] = '{4, 1, 16, 8};

  logic        clk;
  logic        rst_n;
  logic        in_valid_a  [4];
  logic        out_ready_a [4];
  logic        cin_a       [4];
  logic        sub_a       [4];
  logic [31:0] x_a         [4];
  logic [31:0] y_a         [4];
  wire         in_ready_w  [4];
  wire         out_valid_w [4];
  wire         cout_w      [4];
  wire         ovf_w       [4];
  wire  [31:0] z_w         [4];

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int W = WD[g];
    localparam int C = CH[g];
    wire [W-1:0] zl;
    chunked_add_sub #(.WIDTH(W), .CHUNK(C)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_a[g]),
      .in_ready  (in_ready_w[g]),
      .x         (x_a[g][W-1:0]),
      .y         (y_a[g][W-1:0]),
      .cin       (cin_a[g]),
      .sub       (sub_a[g]),
      .out_valid (out_valid_w[g]),
      .out_ready (out_ready_a[g]),
      .z         (zl),
      .cout      (cout_w[g]),
      .ovf       (ovf_w[g])
    );
    assign z_w[g] = 32'(zl);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                input logic c, input logic s,
                                output logic [31:0] zo, output logic co, output logic ov);
    longint mask, ua, ub, sa, sb, ures, sres;
    mask = (longint'(1) << w) - 1;
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    sa   = (ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
    sb   = (ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
    if (s) begin
      ures = ua - ub;
      co   = (ua >= ub);
      sres = sa - sb;
    end else begin
      ures = ua + ub + longint'(c);
      co   = (ures > mask);
      sres = sa + sb + longint'(c);
    end
    zo = 32'(ures & mask);
    ov = (sres > (longint'(1) << (w - 1)) - 1) || (sres < -(longint'(1) << (w - 1)));
  endfunction

  // Drives one operation on instance d and returns observed latency and result.
  task automatic do_op(input int d, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic s, output int lat,
                       output logic [31:0] zo, output logic co, output logic ov);
    @(negedge clk);
    x_a[d] = a; y_a[d] = b; cin_a[d] = c; sub_a[d] = s;
    in_valid_a[d] = 1'b1; out_ready_a[d] = 1'b0;
    @(posedge clk); #1;
    in_valid_a[d] = 1'b0;
    x_a[d] = $urandom; y_a[d] = $urandom; cin_a[d] = ~c; sub_a[d] = ~s;
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      if (out_valid_w[d] === 1'b1) break;
      @(posedge clk);
      lat++;
    end
    zo = z_w[d]; co = cout_w[d]; ov = ovf_w[d];
    out_ready_a[d] = 1'b1;
    @(posedge clk); #1;
    out_ready_a[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid_a[i] = 1'b0; out_ready_a[i] = 1'b0; cin_a[i] = 1'b0; sub_a[i] = 1'b0;
      x_a[i] = '0; y_a[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (in_ready_w[i] !== 1'b1 || out_valid_w[i] !== 1'b0 || z_w[i] !== 32'h0 ||
          cout_w[i] !== 1'b0 || ovf_w[i] !== 1'b0) begin
        bad++;
        $display("FAIL reset dev%0d: rdy=%b vld=%b z=%h co=%b ov=%b want 1 0 0 0 0",
                 i, in_ready_w[i], out_valid_w[i], z_w[i], cout_w[i], ovf_w[i]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] vx [5] = '{32'h1234, 32'hFFFF, 32'h7FFF, 32'h0005, 32'h8000};
    logic [31:0] vy [5] = '{32'h4321, 32'h0001, 32'h0000, 32'h0007, 32'h0001};
    logic        vc [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        vs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] ez [5] = '{32'h5555, 32'h0000, 32'h8000, 32'hFFFE, 32'h7FFF};
    logic        eco[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        eov[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int lat; logic [31:0] zo; logic co, ov;
    for (int i = 0; i < 5; i++) begin
      do_op(0, vx[i], vy[i], vc[i], vs[i], lat, zo, co, ov);
      total++;
      if (lat !== 4) begin
        bad++; $display("FAIL directed%0d latency: got %0d want 4", i, lat);
      end
      total++;
      if (zo !== ez[i] || co !== eco[i] || ov !== eov[i]) begin
        bad++;
        $display("FAIL directed%0d result: got z=%h co=%b ov=%b want z=%h co=%b ov=%b",
                 i, zo, co, ov, ez[i], eco[i], eov[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    x_a[0] = 32'h1234; y_a[0] = 32'h1111; cin_a[0] = 1'b1; sub_a[0] = 1'b0;
    in_valid_a[0] = 1'b1; out_ready_a[0] = 1'b0;
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    n = 0;
    while (out_valid_w[0] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    // Offer a different operation throughout DONE; it must be ignored.
    x_a[0] = 32'hFFFF; y_a[0] = 32'hFFFF; in_valid_a[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (z_w[0] !== 32'h2346 || cout_w[0] !== 1'b0 || ovf_w[0] !== 1'b0 ||
          in_ready_w[0] !== 1'b0 || out_valid_w[0] !== 1'b1) begin
        bad++;
        $display("FAIL hold cyc%0d: z=%h co=%b ov=%b rdy=%b vld=%b want 2346 0 0 0 1",
                 i, z_w[0], cout_w[0], ovf_w[0], in_ready_w[0], out_valid_w[0]);
      end
    end
    in_valid_a[0] = 1'b0;
    out_ready_a[0] = 1'b1;
    @(negedge clk);
    out_ready_a[0] = 1'b0;
    total++;
    if (in_ready_w[0] !== 1'b1 || out_valid_w[0] !== 1'b0 || z_w[0] !== 32'h2346) begin
      bad++;
      $display("FAIL release: rdy=%b vld=%b z=%h want 1 0 2346",
               in_ready_w[0], out_valid_w[0], z_w[0]);
    end
    repeat (6) @(negedge clk);
    total++;
    if (in_ready_w[0] !== 1'b1 || z_w[0] !== 32'h2346) begin
      bad++;
      $display("FAIL idle_after_release: rdy=%b z=%h want 1 2346", in_ready_w[0], z_w[0]);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat; logic [31:0] zo; logic co, ov;
    @(negedge clk);
    x_a[0] = 32'hAAAA; y_a[0] = 32'h5555; cin_a[0] = 1'b1; sub_a[0] = 1'b0;
    in_valid_a[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (z_w[0] !== 32'h0 || cout_w[0] !== 1'b0 || ovf_w[0] !== 1'b0 ||
        in_ready_w[0] !== 1'b1 || out_valid_w[0] !== 1'b0) begin
      bad++;
      $display("FAIL midrun_reset: z=%h co=%b ov=%b rdy=%b vld=%b want 0 0 0 1 0",
               z_w[0], cout_w[0], ovf_w[0], in_ready_w[0], out_valid_w[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(0, 32'h0F0F, 32'hF0F0, 1'b0, 1'b0, lat, zo, co, ov);
    total++;
    if (lat !== 4 || zo !== 32'hFFFF || co !== 1'b0 || ov !== 1'b0) begin
      bad++;
      $display("FAIL after_reset_op: lat=%0d z=%h co=%b ov=%b want 4 ffff 0 0", lat, zo, co, ov);
    end
  endtask

  task automatic test_random_sweep();
    int lat; logic [31:0] zo, ez, a, b; logic co, ov, eco, eov, c, s;
    for (int d = 0; d < 4; d++) begin
      for (int i = 0; i < 25; i++) begin
        a = $urandom; b = $urandom;
        case ($urandom_range(0, 5))
          0: a = 32'hFFFF_FFFF;
          1: b = 32'h8000_0000 >> (32 - WD[d]);
          2: b = a;
          default: ;
        endcase
        c = 1'($urandom); s = 1'($urandom);
        model(WD[d], a, b, c, s, ez, eco, eov);
        do_op(d, a, b, c, s, lat, zo, co, ov);
        total++;
        if (lat !== WD[d] / CH[d]) begin
          bad++;
          $display("FAIL sweep_lat W%0d C%0d: got %0d want %0d", WD[d], CH[d], lat, WD[d] / CH[d]);
        end
        total++;
        if (zo !== ez || co !== eco || ov !== eov) begin
          bad++;
          $display("FAIL sweep W%0d C%0d x=%h y=%h cin=%b sub=%b: got z=%h co=%b ov=%b want z=%h co=%b ov=%b",
                   WD[d], CH[d], a, b, c, s, zo, co, ov, ez, eco, eov);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] zo, ez; logic co, ov, eco, eov;
    for (int i = 0; i < 4; i++) begin
      model(16, 32'h0000_8000 + i, 32'h0000_8000, 1'b0, 1'b0, ez, eco, eov);
      do_op(0, 32'h0000_8000 + i, 32'h0000_8000, 1'b0, 1'b0, lat, zo, co, ov);
      total++;
      if (lat !== 4 || zo !== ez || co !== eco || ov !== eov) begin
        bad++;
        $display("FAIL b2b%0d: lat=%0d z=%h co=%b ov=%b want 4 %h %b %b",
                 i, lat, zo, co, ov, ez, eco, eov);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_random_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/chunked_add_sub.md
Name: chunked_add_sub

Overview:
- Parametrised, multi-cycle successor to the team's 4-bit ripple adder.
- Adds or subtracts two WIDTH-bit operands, CHUNK bits per clock, through one small CHUNK-bit ripple slice with a registered carry between cycles.
- Input side uses a valid/ready handshake; output side holds its result until the consumer accepts it.
- Used where wide arithmetic must trade latency for area.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; 1 <= CHUNK <= WIDTH.
- NCHUNK (localparam), WIDTH/CHUNK, cycles per operation.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept a new operation.
- x  input  WIDTH  operand A.
- y  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  0: z = x + y + cin; 1: z = x - y (computed as x + ~y + 1; cin ignored).
- out_valid  output  1  result fields are valid.
- out_ready  input  1  consumer accepts the result.
- z  output  WIDTH  sum/difference, modulo 2^WIDTH.
- cout  output  1  carry out of MSB; for sub, 1 means no borrow.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, in_ready=1, out_valid=0, z=0, cout=0, ovf=0, chunk counter=0, internal operand/carry registers=0. Reset takes effect immediately, including mid-operation. Any in-flight operation is discarded with no partial output.
- FSM states: IDLE, RUN, DONE.
- in_ready=1 only in IDLE.
- IDLE:
  - On a clk edge with in_valid=1, latch x, y^{WIDTH{sub}}, carry = sub ? 1 : cin, and sub.
  - Clear the counter and go to RUN.
  - With in_valid=0, stay in IDLE.
- RUN:
  - Each cycle, add chunk k of the latched operands plus the carry register.
  - Write CHUNK result bits into z[k*CHUNK +: CHUNK], update the carry register, and increment k.
  - At the edge processing k = NCHUNK-1:
    - cout = final carry.
    - ovf = (A_msb == B'_msb) && (z_msb != A_msb), where B' is the possibly-inverted y.
    - Go to DONE.
- DONE:
  - out_valid=1; z/cout/ovf are stable.
  - On an edge with out_ready=1, go to IDLE and drop out_valid. z/cout/ovf keep their values until the next operation overwrites them.
  - With out_ready=0, hold indefinitely.
- Latency: operation accepted at edge T; out_valid rises after edge T+NCHUNK. Throughput: one operation per NCHUNK+2 cycles at best.
- in_valid and input data changes outside IDLE are ignored. Operands are captured only at acceptance.
- CHUNK = WIDTH degenerates to a single RUN cycle. Behaviour must be identical across legal parameter pairs.
- Out-of-range values are impossible: results wrap modulo 2^WIDTH and carry leaves via cout.

Test Plan (WIDTH=16, CHUNK=4 unless noted):
- Basic add: x=0x1234, y=0x4321, cin=0, sub=0 -> out_valid exactly 4 edges after acceptance; z=0x5555, cout=0, ovf=0.
- Wrap-around: x=0xFFFF, y=0x0001, cin=0 -> z=0x0000, cout=1, ovf=0. Then x=0x7FFF, y=0x0000, cin=1 -> z=0x8000, cout=0, ovf=1.
- Subtract with borrow: x=0x0005, y=0x0007, sub=1, cin=1 (ignored) -> z=0xFFFE, cout=0, ovf=0. Then x=0x8000, y=0x0001, sub=1 -> z=0x7FFF, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> z/cout/ovf stable, in_ready=0, new in_valid ignored. Assert out_ready -> IDLE next edge, in_ready=1.
- Reset mid-run: deassert rst_n asynchronously during chunk 2 -> outputs zero immediately, in_ready=1. Next operation 0x0F0F+0xF0F0 -> z=0xFFFF, cout=0.
- Parameter sweep: repeat random add/sub against a reference model for (WIDTH,CHUNK) = (16,1), (16,16), (32,8). Required: latency = WIDTH/CHUNK and all results match.
